// File: rtl/blink_pkg.sv
// blink_pkg: shared clock/blink rates and the period-meter state encoding.
package blink_pkg;
  localparam int SYS_CLK_HZ   = 100_000_000;
  localparam int BLINK_HZ     = 5;
  localparam int BLINK_PERIOD = SYS_CLK_HZ / BLINK_HZ;
  typedef enum logic {IDLE, MEASURE} meter_state_t;
endpackage

// File: rtl/blink_period_meter_edge_sync.sv
// edge_sync: multi-flop synchronizer with registered rise/fall strobes and
// selectable reset values for the chain and the history flop.
module edge_sync #(
  parameter int   STAGES   = 2,
  parameter logic SYNC_RST = 1'b0,
  parameter logic HIST_RST = 1'b1
) (
  input  logic clock_in,
  input  logic reset,
  input  logic async_in,
  output logic rise,
  output logic fall
);
  logic [STAGES-1:0] chain;
  logic [STAGES-1:0] fill;
  logic              hist;
  logic              synced;
  logic              primed;
  assign synced = chain[STAGES-1];
  assign primed = fill[STAGES-1];
  // History holds its reset value until the chain has filled with real input,
  // so the chain's reset value never masquerades as an edge.
  always_ff @(posedge clock_in) begin
    if (reset) begin
      chain <= {STAGES{SYNC_RST}};
      fill  <= '0;
      hist  <= HIST_RST;
      rise  <= 1'b0;
      fall  <= 1'b0;
    end else begin
      chain <= {chain[STAGES-2:0], async_in};
      fill  <= {fill[STAGES-2:0], 1'b1};
      hist  <= primed ? synced : hist;
      rise  <= primed & synced & ~hist;
      fall  <= primed & ~synced & hist;
    end
  end
endmodule

// File: rtl/blink_period_meter.sv
// blink_period_meter: measures period/high time of a slow async square wave,
// flags an in-window period and reports loss of toggling.
module blink_period_meter
  import blink_pkg::*;
#(
  parameter int CNT_W       = 32,
  parameter int SYNC_STAGES = 2,
  parameter int TIMEOUT     = 200_000_000,
  parameter int PERIOD_MIN  = BLINK_PERIOD - BLINK_PERIOD / 20,
  parameter int PERIOD_MAX  = BLINK_PERIOD + BLINK_PERIOD / 20
) (
  input  logic             clock_in,
  input  logic             reset,
  input  logic             signal_in,
  output logic [CNT_W-1:0] period_out,
  output logic [CNT_W-1:0] high_out,
  output logic             period_valid,
  output logic             timeout_out,
  output logic             blink_ok
);
  meter_state_t     state, state_n;
  logic [CNT_W-1:0] cnt, cnt_n, cnt_inc, high_lat, high_lat_n, period_n, high_n;
  logic             valid_n, timeout_n, ok_n, rise, fall, in_window;
  edge_sync #(.STAGES(SYNC_STAGES), .SYNC_RST(1'b0), .HIST_RST(1'b1)) u_sync (
    .clock_in (clock_in),
    .reset    (reset),
    .async_in (signal_in),
    .rise     (rise),
    .fall     (fall)
  );
  assign cnt_inc   = cnt + 1'b1;
  assign in_window = (cnt_inc >= CNT_W'(PERIOD_MIN)) && (cnt_inc <= CNT_W'(PERIOD_MAX));
  always_ff @(posedge clock_in) begin
    if (reset) begin
      state        <= IDLE;
      cnt          <= '0;
      high_lat     <= '0;
      period_out   <= '0;
      high_out     <= '0;
      period_valid <= 1'b0;
      timeout_out  <= 1'b0;
      blink_ok     <= 1'b0;
    end else begin
      state        <= state_n;
      cnt          <= cnt_n;
      high_lat     <= high_lat_n;
      period_out   <= period_n;
      high_out     <= high_n;
      period_valid <= valid_n;
      timeout_out  <= timeout_n;
      blink_ok     <= ok_n;
    end
  end
  // A rise always takes priority over the timeout, so a period of exactly
  // TIMEOUT clocks is reported rather than flagged.
  always_comb begin
    state_n    = state;
    cnt_n      = '0;
    high_lat_n = rise ? '0 : high_lat;
    period_n   = period_out;
    high_n     = high_out;
    valid_n    = 1'b0;
    timeout_n  = timeout_out;
    ok_n       = blink_ok;
    if (state == IDLE) begin
      state_n   = rise ? MEASURE : IDLE;
      timeout_n = rise ? 1'b0 : timeout_out;
    end else if (rise) begin
      period_n = cnt_inc;
      high_n   = high_lat;
      valid_n  = 1'b1;
      ok_n     = in_window;
    end else if (cnt_inc == CNT_W'(TIMEOUT)) begin
      state_n   = IDLE;
      timeout_n = 1'b1;
      ok_n      = 1'b0;
    end else begin
      cnt_n      = cnt_inc;
      high_lat_n = fall ? cnt_inc : high_lat;
    end
  end
endmodule

// File: tb/tb_blink_period_meter.sv
// tb_blink_period_meter: directed scenarios with hand-computed expectations.
module tb_blink_period_meter;
  logic        clock_in = 1'b0;
  logic        reset = 1'b1;
  logic        signal_in = 1'b1;
  logic [31:0] period_out, high_out;
  logic        period_valid, timeout_out, blink_ok;
  int          checks = 0;
  int          errors = 0;
  int          strobes = 0;
  typedef struct packed {
    logic        v3, v4, v5, ok, to;
    logic [31:0] per, hi;
  } obs_t;
  blink_period_meter #(
    .CNT_W(32), .SYNC_STAGES(2), .TIMEOUT(100), .PERIOD_MIN(18), .PERIOD_MAX(22)
  ) dut (
    .clock_in     (clock_in),
    .reset        (reset),
    .signal_in    (signal_in),
    .period_out   (period_out),
    .high_out     (high_out),
    .period_valid (period_valid),
    .timeout_out  (timeout_out),
    .blink_ok     (blink_ok)
  );
  always #5 clock_in = ~clock_in;
  always @(negedge clock_in) if (period_valid) strobes++;
  task automatic tick(input int n);
    repeat (n) begin
      @(posedge clock_in);
      #1;
    end
  endtask
  // One input period: rise, strobe window samples at +3/+4/+5 clocks, fall at h.
  task automatic pulse(input int p, input int h, output obs_t o);
    signal_in = 1'b1;
    tick(3);
    o.v3 = period_valid;
    tick(1);
    o.v4 = period_valid;
    o.per = period_out;
    o.hi = high_out;
    o.ok = blink_ok;
    o.to = timeout_out;
    tick(1);
    o.v5 = period_valid;
    tick(h - 5);
    signal_in = 1'b0;
    tick(p - h);
  endtask
  function automatic obs_t mk(input logic v4, input logic ok, input logic to, input int per, input int hi);
    mk = '{v3: 1'b0, v4: v4, v5: 1'b0, ok: ok, to: to, per: per, hi: hi};
  endfunction
  task automatic test_reset();
    logic [66:0] got;
    signal_in = 1'b1;
    reset = 1'b1;
    tick(5);
    reset = 1'b0;
    tick(1);
    got = {period_out, high_out, period_valid, timeout_out, blink_ok};
    checks++;
    if (got !== 67'd0) begin errors++; $display("FAIL reset_outputs got %h want 0", got); end
    tick(300);
    got = {period_out, high_out, period_valid, timeout_out, blink_ok};
    checks++;
    if (got !== 67'd0) begin errors++; $display("FAIL reset_high_hold got %h want 0", got); end
    checks++;
    if (strobes !== 0) begin errors++; $display("FAIL reset_no_strobe got %0d want 0", strobes); end
  endtask
  task automatic test_in_window();
    obs_t o;
    signal_in = 1'b0;
    tick(10);
    pulse(20, 10, o);
    checks++;
    if (o !== mk(0, 0, 0, 0, 0)) begin errors++; $display("FAIL arm_no_strobe got %h want %h", o, mk(0, 0, 0, 0, 0)); end
    for (int i = 0; i < 2; i++) begin
      pulse(20, 10, o);
      checks++;
      if (o !== mk(1, 1, 0, 20, 10)) begin errors++; $display("FAIL in_window_%0d got %h want %h", i, o, mk(1, 1, 0, 20, 10)); end
    end
  endtask
  task automatic test_out_of_window();
    obs_t o;
    pulse(30, 5, o);
    checks++;
    if (o !== mk(1, 1, 0, 20, 10)) begin errors++; $display("FAIL oow_prev got %h want %h", o, mk(1, 1, 0, 20, 10)); end
    pulse(30, 5, o);
    checks++;
    if (o !== mk(1, 0, 0, 30, 5)) begin errors++; $display("FAIL oow_30 got %h want %h", o, mk(1, 0, 0, 30, 5)); end
  endtask
  task automatic test_window_edges();
    int   ps[5] = '{22, 23, 18, 17, 20};
    int   pp = 30;
    int   ph = 5;
    obs_t o, e;
    for (int i = 0; i < 5; i++) begin
      pulse(ps[i], ps[i] / 2, o);
      e = mk(1, (pp >= 18) && (pp <= 22), 0, pp, ph);
      checks++;
      if (o !== e) begin errors++; $display("FAIL edge_%0d got %h want %h", pp, o, e); end
      pp = ps[i];
      ph = ps[i] / 2;
    end
  endtask
  task automatic test_timeout();
    obs_t o;
    signal_in = 1'b1;
    tick(4);
    checks++;
    if ({period_valid, period_out} !== {1'b1, 32'd20}) begin errors++; $display("FAIL to_last_strobe got %b/%0d want 1/20", period_valid, period_out); end
    tick(99);
    checks++;
    if (timeout_out !== 1'b0) begin errors++; $display("FAIL to_early got %b want 0", timeout_out); end
    tick(1);
    checks++;
    if ({timeout_out, blink_ok, period_out, high_out} !== {2'b10, 32'd20, 32'd10}) begin
      errors++;
      $display("FAIL to_assert got to=%b ok=%b per=%0d hi=%0d want 1 0 20 10", timeout_out, blink_ok, period_out, high_out);
    end
    signal_in = 1'b0;
    tick(10);
    pulse(20, 10, o);
    checks++;
    if (o !== mk(0, 0, 0, 20, 10)) begin errors++; $display("FAIL to_rearm got %h want %h", o, mk(0, 0, 0, 20, 10)); end
    pulse(20, 10, o);
    checks++;
    if (o !== mk(1, 1, 0, 20, 10)) begin errors++; $display("FAIL to_recover got %h want %h", o, mk(1, 1, 0, 20, 10)); end
  endtask
  task automatic test_period_eq_timeout();
    obs_t        o;
    logic [66:0] got;
    pulse(100, 50, o);
    pulse(20, 10, o);
    checks++;
    if (o !== mk(1, 0, 0, 100, 50)) begin errors++; $display("FAIL eq_timeout got %h want %h", o, mk(1, 0, 0, 100, 50)); end
    signal_in = 1'b1;
    tick(6);
    reset = 1'b1;
    tick(2);
    reset = 1'b0;
    tick(1);
    got = {period_out, high_out, period_valid, timeout_out, blink_ok};
    checks++;
    if (got !== 67'd0) begin errors++; $display("FAIL mid_reset got %h want 0", got); end
    tick(5);
    signal_in = 1'b0;
    tick(10);
    pulse(20, 10, o);
    checks++;
    if (o !== mk(0, 0, 0, 0, 0)) begin errors++; $display("FAIL post_reset_arm got %h want %h", o, mk(0, 0, 0, 0, 0)); end
    pulse(20, 10, o);
    checks++;
    if (o !== mk(1, 1, 0, 20, 10)) begin errors++; $display("FAIL post_reset_meas got %h want %h", o, mk(1, 1, 0, 20, 10)); end
  endtask
  task automatic test_fastest();
    int n = 0;
    for (int i = 0; i < 60; i++) begin
      signal_in = ~signal_in;
      tick(1);
      if (i >= 20 && period_valid) begin
        n++;
        checks++;
        if ({period_out, high_out, blink_ok} !== {32'd2, 32'd1, 1'b0}) begin
          errors++;
          $display("FAIL fast_values got per=%0d hi=%0d ok=%b want 2 1 0", period_out, high_out, blink_ok);
        end
      end
    end
    checks++;
    if (n !== 20) begin errors++; $display("FAIL fast_strobes got %0d want 20", n); end
  endtask
  initial begin
    test_reset();
    test_in_window();
    test_out_of_window();
    test_window_edges();
    test_timeout();
    test_period_eq_timeout();
    test_fastest();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule

// File: doc/blink_period_meter.md
# blink_period_meter

Measures the period and high time of a slow, asynchronous square wave, such as a divided blink clock, against the 100 MHz system clock. It flags whether the period falls inside a programmable window around the nominal 5 Hz blink rate. It also reports loss of toggling via a timeout. It sits on the receive side of the clock-divider outputs and drives LED-status and self-check logic.

## Interface
- `CNT_W`, 32: width of the internal counter and of the period/high outputs; must hold `TIMEOUT`.
- `SYNC_STAGES`, 2: synchronizer depth for `signal_in`; minimum 2.
- `TIMEOUT`, 200_000_000: clocks without a rising edge before `timeout_out` asserts (2 s).
- `PERIOD_MIN`, 19_000_000: lower bound of the acceptable period, inclusive.
- `PERIOD_MAX`, 21_000_000: upper bound of the acceptable period, inclusive.
- `clock_in`  in  1: system clock, 100 MHz; the only clock.
- `reset`  in  1: synchronous, active-high reset.
- `signal_in`  in  1: asynchronous slow square wave under test.
- `period_out`  out  CNT_W: clocks between the last two rising edges.
- `high_out`  out  CNT_W: clocks from rising to falling edge within that period.
- `period_valid`  out  1: one-cycle strobe; `period_out` and `high_out` are new.
- `timeout_out`  out  1: level; no rising edge seen for `TIMEOUT` clocks.
- `blink_ok`  out  1: level; last measured period lies in [`PERIOD_MIN`, `PERIOD_MAX`].

## Operation
- **Synchronizer and edge detector:** `signal_in` passes through `SYNC_STAGES` flops, then a history flop.
  - `rise` = synced & ~hist.
  - `fall` = ~synced & hist.
  - The synchronizer flops reset to 0; the history flop resets to 1. A high input at reset release therefore produces no spurious rise.
- **State machine, IDLE / MEASURE:**
  - IDLE: the counter is held at 0. On `rise`, go to MEASURE, set cnt <= 0, clear `timeout_out`; no `period_valid`.
  - MEASURE, each cycle: cnt <= cnt + 1.
  - MEASURE, on `fall`: high_lat <= cnt + 1.
  - MEASURE, on `rise`: `period_out` <= cnt + 1, `high_out` <= high_lat, `period_valid` <= 1, `blink_ok` <= (PERIOD_MIN ≤ cnt+1 ≤ PERIOD_MAX), cnt <= 0. Stay in MEASURE.
  - MEASURE, timeout: when cnt + 1 == TIMEOUT and there is no `rise` this cycle, set `timeout_out` <= 1 and `blink_ok` <= 0, and go to IDLE. `period_out` and `high_out` keep their last values.
- **Simultaneous `rise` and timeout:** the rise wins. A period equal to `TIMEOUT` is reported as valid and no timeout is raised.
- **No fall within the period** (only possible with a glitch-free high longer than the period, i.e. impossible): `high_lat` keeps its stale value. `high_lat` is cleared to 0 on every `rise`.
- **Arithmetic:** cnt never exceeds `TIMEOUT` − 1, so no wrap-around.
- **Reset:** all outputs are 0, state is IDLE, cnt and `high_lat` are 0. Reset mid-measurement discards the partial period; the next rise only re-arms.

## Timing
- All outputs are registered.
- A `signal_in` rising transition is seen as `rise` `SYNC_STAGES` + 1 clocks later. `period_valid` asserts in the following cycle.
- `period_valid` is high for exactly 1 cycle per measured period. There is no back-pressure, so consumers must sample on the strobe.
- `timeout_out` asserts exactly `TIMEOUT` clocks after the last `rise` cycle. It deasserts in the cycle after the next `rise`.
- Minimum measurable period is 2 clocks (`period_out` = 2, `high_out` = 1).

## Structure
- **Shared package `blink_pkg`:**
  - `SYS_CLK_HZ` = 100_000_000, `BLINK_HZ` = 5.
  - Derived nominal period `BLINK_PERIOD` = SYS_CLK_HZ / BLINK_HZ.
  - The IDLE/MEASURE state enum.
- **Sub-module `edge_sync`:** a parameterized synchronizer plus rise/fall detector with reset value control. It is reused by other slow-input blocks.

## Test plan
Use `TIMEOUT`=100, `PERIOD_MIN`=18, `PERIOD_MAX`=22, `SYNC_STAGES`=2 unless stated.
- **Reset with input high:** release reset with `signal_in`=1 held for 300 clocks -> no `period_valid`, `timeout_out`=0, all outputs 0.
- **In-window square wave:** period 20, high 10 -> first rise gives no strobe; each later rise gives a one-cycle `period_valid` with `period_out`=20, `high_out`=10, `blink_ok`=1, and the strobe appears 4 clocks after the input edge.
- **Out-of-window period:** switch to period 30, high 5 -> `period_out`=30, `high_out`=5, `blink_ok`=0 on that strobe.
- **Timeout and recovery:** stop toggling after a rise -> `timeout_out`=1 exactly 100 clocks after the rise cycle and `blink_ok`=0. On the next rise, `timeout_out` returns to 0 with no strobe; on the following rise, a valid strobe.
- **Period equal to `TIMEOUT`:** period exactly 100 -> `period_valid` with `period_out`=100 and `timeout_out` stays 0. Then assert `reset` mid-period -> all outputs 0 and the next rise gives no strobe.
- **Fastest input:** toggle `signal_in` every clock -> `period_out`=2, `high_out`=1, a strobe every 2 clocks.
